// File: rtl/clk_meas_pkg.sv
// Shared types and helpers for the divided-clock ratio meter.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } meas_state_t;

  localparam int unsigned CNT_W_MAX = 32;
  // Counter saturation pattern; sliced down to the instance counter width.
  localparam logic [CNT_W_MAX-1:0] CNT_SAT_FULL = '1;

  // Unsigned magnitude compare with one extra bit so the difference never wraps.
  function automatic logic within_tol(input logic [CNT_W_MAX-1:0] meas,
                                      input logic [CNT_W_MAX-1:0] exp_v,
                                      input logic [CNT_W_MAX-1:0] tol);
    logic [CNT_W_MAX:0] diff;
    if (meas >= exp_v) diff = {1'b0, meas} - {1'b0, exp_v};
    else               diff = {1'b0, exp_v} - {1'b0, meas};
    return diff <= {1'b0, tol};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus previous-value flop giving a one-cycle rise strobe.
// DUTY_MEAS_EN additionally exposes the synchronized level.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
`ifdef DUTY_MEAS_EN
  output logic level,
`endif
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
`ifdef DUTY_MEAS_EN
  assign level = sync2;
`endif

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures the rise-to-rise period of div_in in clk cycles and checks it against exp_ratio.
// Optional macro DUTY_MEAS_EN adds the high_time output (synchronized high cycles per period).
module clk_ratio_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOL        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_ratio,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
`ifdef DUTY_MEAS_EN
  output logic [CNT_W-1:0] high_time,
`endif
  output logic             locked,
  output logic             err
);

  localparam int unsigned MC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_SAT_FULL[CNT_W-1:0];
  localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_COUNT);

  meas_state_t      state;
  meas_state_t      state_next;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [MC_W-1:0]  mc;
  logic [MC_W-1:0]  mc_plus;
  logic             cnt_sat;
  logic             cmp_en;
  logic             in_tol;

  logic clr_all;
  logic active;
  logic meas;
  logic timeout;
  logic miss;
  logic mc_inc;
  logic mc_clr;
  logic set_lock;
  logic clr_lock;
  logic set_err;

`ifdef DUTY_MEAS_EN
  logic             level;
  logic [CNT_W-1:0] hcnt;
`endif

  sync_edge_det u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (div_in),
`ifdef DUTY_MEAS_EN
    .level (level),
`endif
    .rise  (rise)
  );

  assign cnt_sat = (cnt == CNT_SAT);
  assign cmp_en  = (exp_ratio >= CNT_W'(2));
  assign in_tol  = within_tol(CNT_W_MAX'(cnt), CNT_W_MAX'(exp_ratio), CNT_W_MAX'(TOL));
  assign mc_plus = mc + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A rise coinciding with saturation is measured; only a rise-free saturated cycle times out.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = SEEK;
      SEEK:    if (rise) state_next = MEASURE;
      MEASURE: begin
        if (rise) begin
          if (cmp_en && in_tol && (mc_plus == MC_LOCK)) state_next = LOCKED;
        end else if (cnt_sat) begin
          state_next = SEEK;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (cmp_en && !in_tol) state_next = MEASURE;
        end else if (cnt_sat) begin
          state_next = SEEK;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!en) state_next = IDLE;
  end

  always_comb begin
    clr_all  = !en || (state == IDLE);
    active   = en && ((state == MEASURE) || (state == LOCKED));
    meas     = active && rise;
    timeout  = active && !rise && cnt_sat;
    miss     = meas && cmp_en && !in_tol;
    mc_inc   = meas && cmp_en && in_tol && (state == MEASURE);
    mc_clr   = timeout || miss;
    set_lock = mc_inc && (mc_plus == MC_LOCK);
    clr_lock = timeout || miss;
    set_err  = timeout || (miss && (state == LOCKED));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      mc           <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
    end else begin
      period_valid <= meas;
      if (meas) period <= cnt;

      if (clr_all)       cnt <= '0;
      else if (rise)     cnt <= CNT_W'(1);
      else if (!cnt_sat) cnt <= cnt + 1'b1;

      if (clr_all || mc_clr) mc <= '0;
      else if (mc_inc)       mc <= mc_plus;

      if (clr_all || clr_lock) locked <= 1'b0;
      else if (set_lock)       locked <= 1'b1;

      if (clr_all)      err <= 1'b0;
      else if (set_err) err <= 1'b1;
    end
  end

`ifdef DUTY_MEAS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt      <= '0;
      high_time <= '0;
    end else begin
      if (meas) high_time <= hcnt;
      if (clr_all)                      hcnt <= '0;
      else if (rise)                    hcnt <= CNT_W'(1);
      else if (level && hcnt != CNT_SAT) hcnt <= hcnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed self-checking bench for clk_ratio_meter (TOL=0 and TOL=1 instances share stimulus).
module tb_clk_ratio_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        div_in = 1'b0;
  logic [15:0] exp_ratio = '0;

  logic [15:0] period, period_t1;
  logic        period_valid, period_valid_t1;
  logic        locked, locked_t1;
  logic        err, err_t1;
`ifdef DUTY_MEAS_EN
  logic [15:0] high_time, high_time_t1;
`endif

  int checks = 0;
  int failures = 0;

  bit          gen_on = 1'b0;
  int unsigned nxt_n = 2, nxt_hi = 1;

  clk_ratio_meter #(.CNT_W(16), .LOCK_COUNT(4), .TOL(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .div_in       (div_in),
    .exp_ratio    (exp_ratio),
    .period       (period),
    .period_valid (period_valid),
`ifdef DUTY_MEAS_EN
    .high_time    (high_time),
`endif
    .locked       (locked),
    .err          (err)
  );

  clk_ratio_meter #(.CNT_W(16), .LOCK_COUNT(4), .TOL(1)) dut_t1 (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .div_in       (div_in),
    .exp_ratio    (exp_ratio),
    .period       (period_t1),
    .period_valid (period_valid_t1),
`ifdef DUTY_MEAS_EN
    .high_time    (high_time_t1),
`endif
    .locked       (locked_t1),
    .err          (err_t1)
  );

  always #5 clk = ~clk;

  // Divided-clock source; new ratio takes effect at the start of a period.
  initial begin
    int unsigned ph, cur_n, cur_hi;
    ph = 0; cur_n = 2; cur_hi = 1;
    forever begin
      @(posedge clk);
      #1;
      if (!gen_on) begin
        div_in = 1'b0;
        ph = 0;
        cur_n = nxt_n;
        cur_hi = nxt_hi;
      end else begin
        if (ph == 0) begin
          cur_n = nxt_n;
          cur_hi = nxt_hi;
        end
        div_in = (ph < cur_hi);
        ph = (ph + 1 >= cur_n) ? 0 : ph + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic wait_valid(input int unsigned budget);
    int unsigned n;
    n = 0;
    @(negedge clk);
    n++;
    while (period_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", {31'b0, period_valid}, 1);
  endtask

  task automatic do_reset();
    gen_on = 1'b0;
    en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned n;
    bit found;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_period", {16'b0, period}, 0);
    chk("rst_valid", {31'b0, period_valid}, 0);
    chk("rst_locked", {31'b0, locked}, 0);
    chk("rst_err", {31'b0, err}, 0);
    rst = 1'b0;

    // 1: /2, exp 2 -> lock on the 4th valid period
    exp_ratio = 16'd2;
    nxt_n = 2; nxt_hi = 1;
    en = 1'b1;
    gen_on = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      wait_valid(40);
      chk("t1_period", {16'b0, period}, 2);
      chk("t1_locked", {31'b0, locked}, (i >= 4) ? 1 : 0);
      chk("t1_err", {31'b0, err}, 0);
    end

    // 2: /4 locks, then /8 errors and never relocks
    do_reset();
    exp_ratio = 16'd4;
    nxt_n = 4; nxt_hi = 2;
    en = 1'b1;
    gen_on = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wait_valid(40);
      chk("t2_period4", {16'b0, period}, 4);
    end
    chk("t2_locked", {31'b0, locked}, 1);
    nxt_n = 8; nxt_hi = 4;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      wait_valid(40);
      if (period != 16'd4) found = 1'b1;
    end
    chk("t2_period8", {16'b0, period}, 8);
    chk("t2_err_set", {31'b0, err}, 1);
    chk("t2_unlocked", {31'b0, locked}, 0);
    for (int i = 0; i < 5; i++) begin
      wait_valid(40);
      chk("t2_nolock", {31'b0, locked}, 0);
      chk("t2_err_sticky", {31'b0, err}, 1);
    end

    // 3: /5 against exp 4; accepted only with TOL=1
    do_reset();
    exp_ratio = 16'd4;
    nxt_n = 5; nxt_hi = 2;
    en = 1'b1;
    gen_on = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      wait_valid(40);
      chk("t3_period", {16'b0, period_t1}, 5);
      chk("t3_locked_t1", {31'b0, locked_t1}, (i >= 4) ? 1 : 0);
      chk("t3_err_t1", {31'b0, err_t1}, 0);
    end
    chk("t3_locked_t0", {31'b0, locked}, 0);
    chk("t3_err_t0", {31'b0, err}, 0);

    // exp_ratio < 2 disables comparison
    do_reset();
    exp_ratio = 16'd1;
    nxt_n = 3; nxt_hi = 1;
    en = 1'b1;
    gen_on = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      wait_valid(40);
      chk("dis_period", {16'b0, period}, 3);
      chk("dis_locked", {31'b0, locked}, 0);
      chk("dis_err", {31'b0, err}, 0);
    end

    // 4: lock, stop div_in, timeout after saturation, then relock via SEEK
    do_reset();
    exp_ratio = 16'd4;
    nxt_n = 4; nxt_hi = 2;
    en = 1'b1;
    gen_on = 1'b1;
    for (int i = 1; i <= 5; i++) wait_valid(40);
    chk("t4_locked", {31'b0, locked}, 1);
    gen_on = 1'b0;
    n = 0;
    while (err !== 1'b1 && n < 70000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_timeout_cycles", n, 65535);
    chk("t4_err", {31'b0, err}, 1);
    chk("t4_unlocked", {31'b0, locked}, 0);
    chk("t4_period_hold", {16'b0, period}, 4);
    gen_on = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_valid(40);
      chk("t4_re_period", {16'b0, period}, 4);
      chk("t4_relock", {31'b0, locked}, (i == 4) ? 1 : 0);
      chk("t4_err_sticky", {31'b0, err}, 1);
    end

    // 5: drop en while locked, then reset mid-MEASURE
    en = 1'b0;
    @(negedge clk);
    chk("t5_en_locked", {31'b0, locked}, 0);
    chk("t5_en_err", {31'b0, err}, 0);
    chk("t5_en_period", {16'b0, period}, 4);
    en = 1'b1;
    wait_valid(40);
    wait_valid(40);
    chk("t5_meas_locked", {31'b0, locked}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_period", {16'b0, period}, 0);
    chk("t5_rst_valid", {31'b0, period_valid}, 0);
    chk("t5_rst_locked", {31'b0, locked}, 0);
    chk("t5_rst_err", {31'b0, err}, 0);
    rst = 1'b0;

`ifdef DUTY_MEAS_EN
    // 6: /4 at 50% duty -> high_time 2
    do_reset();
    exp_ratio = 16'd4;
    nxt_n = 4; nxt_hi = 2;
    en = 1'b1;
    gen_on = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_valid(40);
      chk("t6_period", {16'b0, period}, 4);
      chk("t6_high_time", {16'b0, high_time}, 2);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_ratio_meter.md
Name: clk_ratio_meter

Overview:
- Receiving end of our clock-divider outputs: samples a divided clock (div_in) in the fast clk domain.
- Measures its period in clk cycles and compares it against an expected divide ratio.
- Reports lock or error status.
- Used as an on-chip checker for divider outputs such as /2, /4 and /N.

Parameters:
CNT_W, 16, width of period counter and ratio values
LOCK_COUNT, 4, consecutive in-tolerance periods required to assert locked
TOL, 0, allowed absolute deviation (clk cycles) between measured period and exp_ratio

Ports:
clk  input  1  fast reference clock
rst  input  1  synchronous, active-high reset
en  input  1  measurement enable; low forces IDLE
div_in  input  1  divided clock under test, asynchronous to this block's logic (treated as async)
exp_ratio  input  CNT_W  expected period in clk cycles; sampled on every measured edge
period  output  CNT_W  last measured period (rise to rise), clk cycles
period_valid  output  1  one-cycle pulse when period updates
locked  output  1  ratio confirmed
err  output  1  sticky mismatch/timeout flag

Behaviour:
- Reset: clk is the clock; rst is synchronous, active-high. All of the following clear to 0: sync flops, prev flop, counter, match count, period, period_valid, locked, err. State = IDLE.
- Input path:
  - 2-flop synchronizer on div_in, followed by a prev flop.
  - rise = sync2 & ~prev, one clk wide.
  - rise asserts 3 clk edges after a div_in 0->1 change that is stable across sampling.
- Counter cnt: saturating at all-ones. On rise, cnt <= 1; otherwise cnt <= cnt+1 until saturated.
- States:
  - IDLE: en=0. cnt, match count, locked and err held at 0. en=1 -> SEEK.
  - SEEK: wait for first rise. On rise: cnt<=1, -> MEASURE. No period output.
  - MEASURE: on rise:
    - period<=cnt; period_valid pulses the next cycle.
    - If |cnt - exp_ratio| <= TOL, match count increments; else match count <= 0.
    - When the increment makes match count == LOCK_COUNT: locked<=1, -> LOCKED.
  - LOCKED: on rise:
    - period updates.
    - An out-of-tolerance period sets err<=1, clears locked and match count, -> MEASURE.
- Timeout: cnt reaching all-ones in MEASURE or LOCKED -> SEEK, match count<=0, locked<=0, err<=1. A rise in the same cycle as saturation takes priority and is measured normally.
- exp_ratio < 2: comparison disabled. period and period_valid still operate; locked and err are never set by mismatch. Timeout still sets err.
- en deasserted mid-operation: next cycle IDLE. locked and err clear. period holds its last value.
- err: sticky until rst or en=0. period holds between updates.
- Arithmetic: difference is computed as unsigned magnitude in CNT_W+1 bits; no wrap.

Optional Feature:
- Macro DUTY_MEAS_EN.
- Defined:
  - Extra output high_time [CNT_W-1:0] counts clk cycles with sync2=1 since the last rise.
  - high_time is latched alongside period, with the same period_valid pulse.
  - high_time resets to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package clk_meas_pkg:
  - state enum: IDLE, SEEK, MEASURE, LOCKED.
  - localparam for counter saturation value.
  - TOL-compare helper function.
- Sub-module sync_edge_det: 2-flop synchronizer, prev flop and rise output, synchronous active-high reset. Instantiated once.

Test Plan:
1. div_in = clk/2 via a toggle flop on clk, exp_ratio=2, en=1 -> period=2 on every valid, locked=1 after 4 valid pulses, err=0.
2. div_in = clk/4, exp_ratio=4, TOL=0 -> locked. Then switch the source to /8 -> first period=8 causes err=1, locked=0; state returns to MEASURE and never relocks while exp_ratio=4.
3. div_in = /5 with TOL=1, exp_ratio=4 -> periods 5 accepted, locked=1, err=0.
4. After lock, stop div_in (held 0) -> after cnt saturates at 65535, err=1, locked=0, and a restarted div_in needs SEEK then 4 good periods to relock.
5. Drop en mid-LOCKED -> next cycle locked=0, err=0, period unchanged. Assert rst mid-MEASURE -> all outputs 0 on the following edge.
6. With DUTY_MEAS_EN, div_in = clk/4 at 50% duty -> high_time=2 with every period=4.
